// File: rtl/csr_trap_unit_pkg.sv
// Shared constants for the machine-mode CSR/trap sequencer: CSR addresses,
// request opcodes, Zicsr funct3 codes, trap causes and mstatus field helpers.
package riscy_csr_pkg;

    // Machine-mode CSR addresses touched by the sequencer
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    // Request opcodes from decode
    localparam logic [2:0] OP_CSR     = 3'b000;
    localparam logic [2:0] OP_ECALL   = 3'b001;
    localparam logic [2:0] OP_EBREAK  = 3'b010;
    localparam logic [2:0] OP_ILLEGAL = 3'b011;
    localparam logic [2:0] OP_MRET    = 3'b100;

    // Zicsr funct3 codes; 000 and 100 are not CSR instructions
    localparam logic [2:0] F3_RSVD0 = 3'b000;
    localparam logic [2:0] F3_RW    = 3'b001;
    localparam logic [2:0] F3_RS    = 3'b010;
    localparam logic [2:0] F3_RC    = 3'b011;
    localparam logic [2:0] F3_RSVD4 = 3'b100;
    localparam logic [2:0] F3_RWI   = 3'b101;
    localparam logic [2:0] F3_RSI   = 3'b110;
    localparam logic [2:0] F3_RCI   = 3'b111;

    // mcause values for the synchronous exceptions handled here
    localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;

    // mstatus field positions
    localparam int unsigned MSTATUS_MIE    = 32'd3;
    localparam int unsigned MSTATUS_MPIE   = 32'd7;
    localparam int unsigned MSTATUS_MPP_LO = 32'd11;
    localparam int unsigned MSTATUS_MPP_HI = 32'd12;

    // Request classification after decoding op and funct3
    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_CSR  = 2'd1,
        KIND_TRAP = 2'd2,
        KIND_MRET = 2'd3
    } req_kind_e;

    // mstatus on trap entry: stash MIE in MPIE, disable interrupts, MPP=M
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] old_val);
        logic [31:0] v;
        v = old_val;
        v[MSTATUS_MPIE] = old_val[MSTATUS_MIE];
        v[MSTATUS_MIE]  = 1'b0;
        v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return v;
    endfunction

    // mstatus on MRET: restore MIE from MPIE, set MPIE, MPP stays M (M-mode only)
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] old_val);
        logic [31:0] v;
        v = old_val;
        v[MSTATUS_MIE]  = old_val[MSTATUS_MPIE];
        v[MSTATUS_MPIE] = 1'b1;
        v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return v;
    endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// Bundle of the request handshake, CSR file port and completion signals.
// master = pipeline/CSR-file side, slave = the sequencer.
interface csr_trap_unit_if;
    import riscy_csr_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [2:0]  req_funct3;
    logic [11:0] req_csr;
    logic [31:0] req_src;
    logic [4:0]  req_src_idx;
    logic [31:0] req_pc;
    logic [31:0] req_instr;
    logic        csr_ren;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        done;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output req_valid, req_op, req_funct3, req_csr, req_src, req_src_idx,
               req_pc, req_instr, csr_rdata,
        input  req_ready, csr_ren, csr_raddr, csr_wen, csr_waddr, csr_wdata,
               done, rd_valid, rd_data, redirect, redirect_pc
    );

    modport slave (
        input  req_valid, req_op, req_funct3, req_csr, req_src, req_src_idx,
               req_pc, req_instr, csr_rdata,
        output req_ready, csr_ren, csr_raddr, csr_wen, csr_waddr, csr_wdata,
               done, rd_valid, rd_data, redirect, redirect_pc
    );
endinterface

// File: rtl/csr_trap_unit_alu.sv
// Zicsr read-modify-write datapath: new CSR value and a flag that
// suppresses the write for set/clear with a zero rs1 index / zimm.
module csr_alu
    import riscy_csr_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] old_val,
    input  logic [31:0] src,
    input  logic [4:0]  src_idx,
    output logic [31:0] wdata,
    output logic        suppress
);

    logic [31:0] operand_s;

    // Select operand (register or zimm) and compute the new value
    always_comb begin
        wdata    = old_val;
        suppress = 1'b1;
        if (funct3[2]) begin
            operand_s = {27'd0, src_idx};
        end else begin
            operand_s = src;
        end
        case (funct3)
            F3_RW, F3_RWI: begin
                wdata    = operand_s;
                suppress = 1'b0;
            end
            F3_RS, F3_RSI: begin
                wdata    = old_val | operand_s;
                suppress = (src_idx == 5'd0);
            end
            F3_RC, F3_RCI: begin
                wdata    = old_val & ~operand_s;
                suppress = (src_idx == 5'd0);
            end
            default: begin
                wdata    = old_val;
                suppress = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Sequencer between execute and the M-mode CSR file: Zicsr RMW, trap entry
// (ECALL/EBREAK/illegal) and MRET, one CSR read and one write per cycle.
module csr_trap_unit
    import riscy_csr_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    csr_trap_unit_if.slave  bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CSR_EX  = 3'd1;
    localparam logic [2:0] S_T_EPC   = 3'd2;
    localparam logic [2:0] S_T_CAUSE = 3'd3;
    localparam logic [2:0] S_T_TVAL  = 3'd4;
    localparam logic [2:0] S_T_STAT  = 3'd5;
    localparam logic [2:0] S_M_EPC   = 3'd6;
    localparam logic [2:0] S_M_STAT  = 3'd7;

    logic [2:0]  state_r, state_nxt_s;
    req_kind_e   kind_s;
    logic        accept_s;
    logic [31:0] cause_s, tval_s;
    logic [2:0]  funct3_r;
    logic [11:0] csr_r;
    logic [31:0] src_r;
    logic [4:0]  src_idx_r;
    logic [31:0] epc_r, cause_r, tval_r, vec_r, mstatus_r;
    logic        done_r, rd_valid_r, redirect_r;
    logic [31:0] rd_data_r, redirect_pc_r;
    logic [31:0] alu_wdata_s;
    logic        alu_suppress_s;

    csr_alu u_alu (
        .funct3   (funct3_r),
        .old_val  (bus.csr_rdata),
        .src      (src_r),
        .src_idx  (src_idx_r),
        .wdata    (alu_wdata_s),
        .suppress (alu_suppress_s)
    );

    // Classify the incoming request; reserved funct3 becomes an illegal trap
    always_comb begin
        kind_s  = KIND_NONE;
        cause_s = 32'd0;
        tval_s  = 32'd0;
        case (bus.req_op)
            OP_CSR: begin
                if ((bus.req_funct3 == F3_RSVD0) || (bus.req_funct3 == F3_RSVD4)) begin
                    kind_s  = KIND_TRAP;
                    cause_s = CAUSE_ILLEGAL;
                    tval_s  = bus.req_instr;
                end else begin
                    kind_s  = KIND_CSR;
                end
            end
            OP_ECALL: begin
                kind_s  = KIND_TRAP;
                cause_s = CAUSE_ECALL_M;
            end
            OP_EBREAK: begin
                kind_s  = KIND_TRAP;
                cause_s = CAUSE_BREAKPOINT;
                tval_s  = bus.req_pc;
            end
            OP_ILLEGAL: begin
                kind_s  = KIND_TRAP;
                cause_s = CAUSE_ILLEGAL;
                tval_s  = bus.req_instr;
            end
            OP_MRET: kind_s = KIND_MRET;
            default: kind_s = KIND_NONE;
        endcase
    end

    assign accept_s      = bus.req_valid && (state_r == S_IDLE) && (kind_s != KIND_NONE);
    assign bus.req_ready = (state_r == S_IDLE);

    // Next state and CSR file port; idle ports are driven to zero so the
    // file's address-match forwarding never picks up stale data
    always_comb begin
        state_nxt_s   = state_r;
        bus.csr_ren   = 1'b0;
        bus.csr_raddr = 12'h000;
        bus.csr_wen   = 1'b0;
        bus.csr_waddr = 12'h000;
        bus.csr_wdata = 32'd0;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    bus.csr_ren = 1'b1;
                    case (kind_s)
                        KIND_CSR: begin
                            bus.csr_raddr = bus.req_csr;
                            state_nxt_s   = S_CSR_EX;
                        end
                        KIND_MRET: begin
                            bus.csr_raddr = CSR_MEPC;
                            state_nxt_s   = S_M_EPC;
                        end
                        KIND_TRAP: begin
                            bus.csr_raddr = CSR_MTVEC;
                            state_nxt_s   = S_T_EPC;
                        end
                        default: begin
                            bus.csr_ren = 1'b0;
                            state_nxt_s = S_IDLE;
                        end
                    endcase
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CSR_EX: begin
                if (alu_suppress_s) begin
                    bus.csr_wen = 1'b0;
                end else begin
                    bus.csr_wen   = 1'b1;
                    bus.csr_waddr = csr_r;
                    bus.csr_wdata = alu_wdata_s;
                end
                state_nxt_s = S_IDLE;
            end
            S_T_EPC: begin
                bus.csr_wen   = 1'b1;
                bus.csr_waddr = CSR_MEPC;
                bus.csr_wdata = epc_r;
                bus.csr_ren   = 1'b1;
                bus.csr_raddr = CSR_MSTATUS;
                state_nxt_s   = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                bus.csr_wen   = 1'b1;
                bus.csr_waddr = CSR_MCAUSE;
                bus.csr_wdata = cause_r;
                state_nxt_s   = S_T_TVAL;
            end
            S_T_TVAL: begin
                bus.csr_wen   = 1'b1;
                bus.csr_waddr = CSR_MTVAL;
                bus.csr_wdata = tval_r;
                state_nxt_s   = S_T_STAT;
            end
            S_T_STAT: begin
                bus.csr_wen   = 1'b1;
                bus.csr_waddr = CSR_MSTATUS;
                bus.csr_wdata = mstatus_on_trap(mstatus_r);
                state_nxt_s   = S_IDLE;
            end
            S_M_EPC: begin
                bus.csr_ren   = 1'b1;
                bus.csr_raddr = CSR_MSTATUS;
                state_nxt_s   = S_M_STAT;
            end
            S_M_STAT: begin
                bus.csr_wen   = 1'b1;
                bus.csr_waddr = CSR_MSTATUS;
                bus.csr_wdata = mstatus_on_mret(bus.csr_rdata);
                state_nxt_s   = S_IDLE;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register; reset aborts any sequence in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture request fields at accept and CSR values read during the sequence
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            funct3_r  <= 3'd0;
            csr_r     <= 12'h000;
            src_r     <= 32'd0;
            src_idx_r <= 5'd0;
            epc_r     <= 32'd0;
            cause_r   <= 32'd0;
            tval_r    <= 32'd0;
            vec_r     <= 32'd0;
            mstatus_r <= 32'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        funct3_r  <= bus.req_funct3;
                        csr_r     <= bus.req_csr;
                        src_r     <= bus.req_src;
                        src_idx_r <= bus.req_src_idx;
                        epc_r     <= bus.req_pc & ~32'd3;
                        cause_r   <= cause_s;
                        tval_r    <= tval_s;
                    end
                end
                S_T_EPC, S_M_EPC: vec_r <= bus.csr_rdata;
                S_T_CAUSE:        mstatus_r <= bus.csr_rdata;
                default: begin
                end
            endcase
        end
    end

    // Registered completion pulse with rd writeback or fetch redirect
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_r        <= 1'b0;
            rd_valid_r    <= 1'b0;
            rd_data_r     <= 32'd0;
            redirect_r    <= 1'b0;
            redirect_pc_r <= 32'd0;
        end else begin
            done_r        <= 1'b0;
            rd_valid_r    <= 1'b0;
            rd_data_r     <= 32'd0;
            redirect_r    <= 1'b0;
            redirect_pc_r <= 32'd0;
            case (state_r)
                S_CSR_EX: begin
                    done_r     <= 1'b1;
                    rd_valid_r <= 1'b1;
                    rd_data_r  <= bus.csr_rdata;
                end
                S_T_STAT: begin
                    done_r        <= 1'b1;
                    redirect_r    <= 1'b1;
                    redirect_pc_r <= {vec_r[31:2], 2'b00};
                end
                S_M_STAT: begin
                    done_r        <= 1'b1;
                    redirect_r    <= 1'b1;
                    redirect_pc_r <= vec_r;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.done        = done_r;
    assign bus.rd_valid    = rd_valid_r;
    assign bus.rd_data     = rd_data_r;
    assign bus.redirect    = redirect_r;
    assign bus.redirect_pc = redirect_pc_r;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench: directed scenarios then random requests against an
// architectural CSR model; a registered CSR file model serves the DUT.
module tb_csr_trap_unit;
    import riscy_csr_pkg::*;

    logic clock = 1'b0;
    logic reset;
    csr_trap_unit_if bus();

    csr_trap_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    logic [31:0] file_mem [0:4095];
    logic [31:0] ref_csr  [0:4095];
    logic [11:0] addr_list [0:6] = '{12'h340, 12'h305, 12'h300, 12'h341,
                                     12'h342, 12'h343, 12'h7C0};
    int n_checks = 0;
    int n_pass   = 0;

    // CSR file: registered read with write-data forwarding on address match
    always @(posedge clock) begin
        if (bus.csr_wen) file_mem[bus.csr_waddr] <= bus.csr_wdata;
        bus.csr_rdata <= (bus.csr_raddr == bus.csr_waddr) ? bus.csr_wdata
                                                           : file_mem[bus.csr_raddr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic scramble_req();
        bus.req_op      = 3'($urandom);
        bus.req_funct3  = 3'($urandom);
        bus.req_csr     = 12'($urandom);
        bus.req_src     = $urandom;
        bus.req_src_idx = 5'($urandom);
        bus.req_pc      = $urandom;
        bus.req_instr   = $urandom;
    endtask

    // Issue one request at the current negedge and check it to completion.
    // Returns at the negedge of the done cycle so the next one is back-to-back.
    task automatic do_req(input logic [2:0] op, input logic [2:0] f3, input logic [11:0] csr,
                          input logic [31:0] src, input logic [4:0] idx,
                          input logic [31:0] pc, input logic [31:0] instr);
        logic        e_wen   [1:5];
        logic [11:0] e_waddr [1:5];
        logic [31:0] e_wdata [1:5];
        logic [11:0] e_raddr;
        int          dcyc;
        logic        trap, e_rdv, e_redir;
        logic [31:0] e_rd, e_pc, cause, tval, old, opnd, ms;
        for (int k = 1; k <= 5; k++) begin
            e_wen[k] = 1'b0; e_waddr[k] = 12'h000; e_wdata[k] = 32'd0;
        end
        trap = 1'b0; e_rdv = 1'b0; e_redir = 1'b0; e_rd = 32'd0; e_pc = 32'd0;
        cause = 32'd0; tval = 32'd0; dcyc = 2; e_raddr = 12'h000;
        if (op == 3'd0 && (f3 == 3'b000 || f3 == 3'b100)) begin trap = 1'b1; cause = 32'd2;  tval = instr; end
        else if (op == 3'd1) begin trap = 1'b1; cause = 32'd11; tval = 32'd0; end
        else if (op == 3'd2) begin trap = 1'b1; cause = 32'd3;  tval = pc;    end
        else if (op == 3'd3) begin trap = 1'b1; cause = 32'd2;  tval = instr; end

        if (trap) begin
            e_raddr = 12'h305; dcyc = 5;
            ms = ref_csr[12'h300];
            e_redir = 1'b1; e_pc = ref_csr[12'h305] & 32'hFFFF_FFFC;
            e_wen[1] = 1'b1; e_waddr[1] = 12'h341; e_wdata[1] = pc & 32'hFFFF_FFFC;
            e_wen[2] = 1'b1; e_waddr[2] = 12'h342; e_wdata[2] = cause;
            e_wen[3] = 1'b1; e_waddr[3] = 12'h343; e_wdata[3] = tval;
            e_wen[4] = 1'b1; e_waddr[4] = 12'h300;
            e_wdata[4] = (ms & ~32'h0000_1888) | (ms[3] ? 32'h80 : 32'h0) | 32'h1800;
        end else if (op == 3'd0) begin
            e_raddr = csr; dcyc = 2;
            old = ref_csr[csr];
            opnd = f3[2] ? {27'd0, idx} : src;
            e_rdv = 1'b1; e_rd = old;
            if (f3[1:0] == 2'b01) begin
                e_wen[1] = 1'b1; e_wdata[1] = opnd;
            end else if (idx != 5'd0) begin
                e_wen[1] = 1'b1;
                e_wdata[1] = (f3[1:0] == 2'b10) ? (old | opnd) : (old & ~opnd);
            end
            if (e_wen[1]) e_waddr[1] = csr;
        end else begin
            e_raddr = 12'h341; dcyc = 3;
            ms = ref_csr[12'h300];
            e_redir = 1'b1; e_pc = ref_csr[12'h341];
            e_wen[2] = 1'b1; e_waddr[2] = 12'h300;
            e_wdata[2] = (ms & ~32'h0000_0088) | (ms[7] ? 32'h8 : 32'h0) | 32'h1880;
        end
        for (int k = 1; k <= 5; k++)
            if (e_wen[k]) ref_csr[e_waddr[k]] = e_wdata[k];

        bus.req_valid = 1'b1; bus.req_op = op; bus.req_funct3 = f3; bus.req_csr = csr;
        bus.req_src = src; bus.req_src_idx = idx; bus.req_pc = pc; bus.req_instr = instr;
        #1;
        check_val("ready_at_accept", bus.req_ready, 32'd1);
        check_val("ren_at_accept", bus.csr_ren, 32'd1);
        check_val("raddr_at_accept", bus.csr_raddr, e_raddr);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        scramble_req();
        for (int k = 1; k <= dcyc; k++) begin
            @(negedge clock);
            if (k < dcyc) begin
                check_val("wen", bus.csr_wen, e_wen[k]);
                check_val("waddr", bus.csr_waddr, e_waddr[k]);
                check_val("wdata", bus.csr_wdata, e_wdata[k]);
                check_val("done_early", bus.done, 32'd0);
            end else begin
                check_val("done", bus.done, 32'd1);
                check_val("ready_at_done", bus.req_ready, 32'd1);
                check_val("rd_valid", bus.rd_valid, e_rdv);
                if (e_rdv) check_val("rd_data", bus.rd_data, e_rd);
                check_val("redirect", bus.redirect, e_redir);
                if (e_redir) check_val("redirect_pc", bus.redirect_pc, e_pc);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) begin
            file_mem[a] = 32'd0;
            ref_csr[a]  = 32'd0;
        end
        reset = 1'b0;
        bus.req_valid = 1'b0;
        scramble_req();
        repeat (3) @(negedge clock);
        check_val("rst_ready", bus.req_ready, 32'd1);
        check_val("rst_done", bus.done, 32'd0);
        check_val("rst_rd_valid", bus.rd_valid, 32'd0);
        check_val("rst_rd_data", bus.rd_data, 32'd0);
        check_val("rst_redirect", bus.redirect, 32'd0);
        check_val("rst_redirect_pc", bus.redirect_pc, 32'd0);
        check_val("rst_wen", bus.csr_wen, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // directed scenarios
        do_req(3'd0, 3'b001, 12'h340, 32'hDEADBEEF, 5'd3, 32'h0, 32'h0);      // CSRRW
        do_req(3'd0, 3'b010, 12'h340, 32'hFFFF_FFFF, 5'd0, 32'h0, 32'h0);     // CSRRS x0
        do_req(3'd0, 3'b111, 12'h340, 32'h0, 5'h0F, 32'h0, 32'h0);            // CSRRCI
        check_val("csrrci_result", file_mem[12'h340], 32'hDEADBEE0);
        do_req(3'd0, 3'b001, 12'h305, 32'h2001, 5'd1, 32'h0, 32'h0);
        do_req(3'd0, 3'b001, 12'h300, 32'h8, 5'd1, 32'h0, 32'h0);
        do_req(3'd1, 3'b000, 12'h000, 32'h0, 5'd0, 32'h100, 32'h0);           // ECALL
        check_val("ecall_mstatus", file_mem[12'h300], 32'h1880);
        do_req(3'd0, 3'b000, 12'h340, 32'h0, 5'd0, 32'h44, 32'h0);            // illegal via funct3
        do_req(3'd2, 3'b000, 12'h000, 32'h0, 5'd0, 32'h48, 32'h12345);        // EBREAK
        do_req(3'd0, 3'b001, 12'h341, 32'h104, 5'd1, 32'h0, 32'h0);
        do_req(3'd0, 3'b001, 12'h300, 32'h1880, 5'd1, 32'h0, 32'h0);
        do_req(3'd4, 3'b000, 12'h000, 32'h0, 5'd0, 32'h0, 32'h0);             // MRET
        check_val("mret_mstatus", file_mem[12'h300], 32'h1888);

        // unsupported opcode is not accepted
        bus.req_valid = 1'b1; bus.req_op = 3'(5 + $urandom_range(0, 2));
        #1;
        check_val("badop_ren", bus.csr_ren, 32'd0);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        check_val("badop_ready", bus.req_ready, 32'd1);
        check_val("badop_wen", bus.csr_wen, 32'd0);
        check_val("badop_done", bus.done, 32'd0);

        // random requests
        for (int i = 0; i < 150; i++) begin
            int sel;
            logic [2:0] op;
            sel = $urandom_range(0, 9);
            op = (sel <= 5) ? 3'd0 : 3'(sel - 5);
            do_req(op, 3'($urandom), addr_list[$urandom_range(0, 6)], $urandom,
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom);
        end

        // reset in the middle of a trap (during T_CAUSE)
        bus.req_valid = 1'b1; bus.req_op = 3'd1; bus.req_pc = 32'h208;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        check_val("mid_wen_epc", bus.csr_waddr, 32'h341);
        @(negedge clock);
        check_val("mid_wen_cause", bus.csr_waddr, 32'h342);
        reset = 1'b0;
        #1;
        check_val("mid_rst_wen", bus.csr_wen, 32'd0);
        ref_csr[12'h341] = 32'h208;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_val("in_rst_wen", bus.csr_wen, 32'd0);
            check_val("in_rst_done", bus.done, 32'd0);
        end
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check_val("post_rst_ready", bus.req_ready, 32'd1);
            check_val("post_rst_done", bus.done, 32'd0);
            check_val("post_rst_wen", bus.csr_wen, 32'd0);
        end
        check_val("mid_rst_mcause_kept", file_mem[12'h342], ref_csr[12'h342]);
        do_req(3'd0, 3'b010, 12'h341, 32'h1, 5'd4, 32'h0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Sequencer between decode/execute and the machine-mode CSR register file: executes Zicsr read-modify-write instructions and performs trap entry (ECALL, EBREAK, illegal instruction) and MRET. It drives the file's single read port and single write port, returns the old CSR value for rd, and issues a PC redirect for traps and MRET. The pipeline stalls while req_ready is low.

## Interface
- No parameters. XLEN fixed at 32; M-mode only.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- req_valid  in  1  request present; accepted when req_valid && req_ready.
- req_ready  out  1  high only in IDLE.
- req_op  in  3  000 CSR, 001 ECALL, 010 EBREAK, 011 ILLEGAL, 100 MRET; others ignored (no accept).
- req_funct3  in  3  Zicsr funct3.
- req_csr  in  12  CSR address.
- req_src  in  32  rs1 value.
- req_src_idx  in  5  rs1 index / zimm field.
- req_pc  in  32  PC of the instruction.
- req_instr  in  32  instruction word (mtval on illegal).
- csr_ren  out  1  read address meaningful.
- csr_raddr  out  12  read address; data returns next cycle.
- csr_rdata  in  32  registered read data.
- csr_wen  out  1  write strobe.
- csr_waddr  out  12  write address.
- csr_wdata  out  32  write data.
- done  out  1  one-cycle completion pulse.
- rd_valid  out  1  with done: rd_data must be written to rd.
- rd_data  out  32  old CSR value.
- redirect  out  1  with done: fetch from redirect_pc.
- redirect_pc  out  32  trap vector or mepc.

## Operation
- States: IDLE, CSR_EX, T_EPC, T_CAUSE, T_TVAL, T_STAT, M_EPC, M_STAT.
- CSR file forwards wd whenever read and write addresses match, regardless of wen: when csr_wen=0, csr_waddr=12'h000 and csr_wdata=0; when csr_ren=0, csr_raddr=12'h000.
- IDLE accept, op CSR: csr_raddr=req_csr; latch funct3, csr, src, src_idx. funct3 000 or 100 is converted to the ILLEGAL path. Next CSR_EX.
- CSR_EX: old=csr_rdata. RW: new=src; RS: old|src; RC: old&~src; RWI/RSI/RCI use zero-extended src_idx. RS/RC(I) with src_idx==0: no write. RW always writes. rd_data=old, rd_valid=1.
- ECALL/EBREAK/ILLEGAL accept: csr_raddr=0x305 (mtvec). T_EPC: latch mtvec, write mepc(0x341)=pc&~3, read 0x300. T_CAUSE: latch mstatus, write mcause(0x342)=11/3/2. T_TVAL: write mtval(0x343)=0 (ECALL), pc (EBREAK), instr (ILLEGAL). T_STAT: write mstatus with bit7 MPIE=old bit3, bit3 MIE=0, bits12:11 MPP=2'b11, other bits kept. redirect_pc={mtvec[31:2],2'b00} (direct mode only).
- MRET accept: read 0x341. M_EPC: latch mepc, read 0x300. M_STAT: write mstatus with MIE=old MPIE, MPIE=1, MPP=2'b11. redirect_pc=mepc.

## Timing
- Reset values: state IDLE, req_ready=1, all other outputs 0, latches 0.
- done, rd_valid, rd_data, redirect, redirect_pc registered; pulse one cycle after the last work state, same cycle state is IDLE; a new request may be accepted that cycle.
- Accept edge = cycle 0. CSR: write in cycle 1, done cycle 2. Trap: writes cycles 1–4, done cycle 5. MRET: write cycle 2, done cycle 3.
- Back-to-back ops on the same CSR see the prior write (read issued after write edge).
- req_* sampled only at accept; later changes ignored.
- Reset mid-sequence: immediate IDLE, no further writes, no done.

## Structure
- Package riscy_csr_pkg: CSR addresses (0x300, 0x305, 0x341–0x343), req_op encodings, funct3 codes, cause codes 2/3/11, mstatus bit positions MIE=3, MPIE=7, MPP=12:11.
- Sub-module csr_alu: combinational RW/RS/RC(I) compute plus write-suppress flag; instanced once.

## Test plan
- CSRRW 0x340, src 0xDEADBEEF, prior 0x0: wen cycle 1 waddr 0x340 wdata 0xDEADBEEF; done cycle 2 rd_data 0x0.
- CSRRS 0x340 src_idx 0 after above: no wen; rd_data 0xDEADBEEF. CSRRCI zimm 5'h0F: wdata 0xDEADBEE0.
- ECALL pc 0x100, mtvec 0x2001, mstatus 0x8: writes mepc 0x100, mcause 11, mtval 0, mstatus 0x1880; redirect_pc 0x2000 at cycle 5.
- Illegal instr 0x00000000 via funct3 000 at pc 0x44: mcause 2, mtval 0; EBREAK: mcause 3, mtval=pc.
- MRET with mepc 0x104, mstatus 0x1880: mstatus written 0x1888; redirect_pc 0x104 at cycle 3.
- Reset low during T_CAUSE: no further wen, done never pulses, req_ready 1 after release.
